dm_arbiter: RTL and testbench

- Shares the single-port 1 KB data memory (dm_1k) between two requesters: port 0 (CPU load/store unit) and port 1 (debug/loader).
- Round-robin arbitration with a req/ack handshake.
- Byte-enable writes: dm_1k only writes whole words, so partial stores run as a read-modify-write sequence.
- Sits between the requesters and the dm_1k instance; it is the only driver of the dm_1k write enable, address and write data.

---
 rtl/dm_arbiter.sv | 146 ++++++++++++++
 tb/tb_dm_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of the single-port 1 KB
// data memory (dm_1k). Port 0 is the CPU load/store unit and port 1 is the
// debug/loader. dm_1k only writes whole words, so a store with a partial byte
// mask runs as a read-modify-write: the old word is read, the enabled lanes
// are merged in, and the result is written back one cycle later.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   pX_req                request, held with all fields stable until pX_ack
//   pX_wr                 1 = write, 0 = read
//   pX_be[3:0]            byte enables, be[0] selects bits 7:0
//   pX_addr[AW-1:0]       byte address (addr[1:0] ignored, word aligned)
//   pX_wdata[DW-1:0]      write data
//   pX_ack                one-cycle completion pulse
//   pX_rdata[DW-1:0]      read data, holds until the next read on that port
//   dm_we/dm_addr/dm_din  memory write enable, address, write data
//   dm_dout               combinational memory read of word dm_addr[AW-1:2]
module dm_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_wr,
    input  logic [3:0]    p0_be,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_wr,
    input  logic [3:0]    p1_be,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
);

    localparam int LW = DW / 4;  // byte-lane width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          lat_port;
    logic          lat_wr;
    logic [3:0]    lat_be;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] merge;

    // A request seen in its own ack cycle is the one just completed.
    logic p0_elig, p1_elig, grant_any, grant_port;
    assign p0_elig    = p0_req & ~p0_ack;
    assign p1_elig    = p1_req & ~p1_ack;
    assign grant_any  = p0_elig | p1_elig;
    assign grant_port = (p0_elig & p1_elig) ? ~last_grant : p1_elig;

    logic be_full, be_none;
    assign be_full = (lat_be == 4'hF);
    assign be_none = (lat_be == 4'h0);

    // Merge the enabled lanes of the write data over the word read back.
    logic [DW-1:0] merge_next;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        merge_next = dm_dout;
        for (int k = 0; k < 4; k++) begin
            if (lat_be[k])
                merge_next[k*LW +: LW] = lat_wdata[k*LW +: LW];
        end
    end

    // Memory-side outputs are decoded from the state register, so an
    // asynchronous reset pulls dm_we low at once without waiting for an edge.
    assign dm_addr = {lat_addr[AW-1:2], 2'b00};
    assign dm_we   = (state == MERGE) || ((state == ACCESS) && lat_wr && be_full);
    assign dm_din  = (state == MERGE) ? merge : lat_wdata;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_wr     <= 1'b0;
            lat_be     <= 4'h0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            merge      <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_port;
                        lat_port   <= grant_port;
                        lat_wr     <= grant_port ? p1_wr    : p0_wr;
                        lat_be     <= grant_port ? p1_be    : p0_be;
                        lat_addr   <= grant_port ? p1_addr  : p0_addr;
                        lat_wdata  <= grant_port ? p1_wdata : p0_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_wr && !be_full && !be_none) begin
                        // Partial store: dm_dout holds the old word this cycle.
                        merge <= merge_next;
                        state <= MERGE;
                    end else begin
                        if (!lat_wr) begin
                            if (lat_port) p1_rdata <= dm_dout;
                            else          p0_rdata <= dm_dout;
                        end
                        if (lat_port) p1_ack <= 1'b1;
                        else          p0_ack <= 1'b1;
                        state <= IDLE;
                    end
                end
                MERGE: begin
                    if (lat_port) p1_ack <= 1'b1;
                    else          p0_ack <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a behavioural dm_1k model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Cycle 1 of a transaction is the first cycle with req high.
module tb_dm_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 0, p0_wr = 0;
    logic [3:0]    p0_be = 0;
    logic [AW-1:0] p0_addr = 0;
    logic [DW-1:0] p0_wdata = 0;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 0, p1_wr = 0;
    logic [3:0]    p1_be = 0;
    logic [AW-1:0] p1_addr = 0;
    logic [DW-1:0] p1_wdata = 0;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic [DW-1:0] dm_dout;

    int checks = 0;
    int failures = 0;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_be(p0_be), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_be(p1_be), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // dm_1k model: 256 words, combinational read, write on rising edge.
    logic [DW-1:0] mem [256];
    assign dm_dout = mem[dm_addr[AW-1:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[AW-1:2]] <= dm_din;

    // Event counters sampled mid-cycle.
    int we_cnt = 0, both_cnt = 0, p0_ack_cnt = 0, p1_ack_cnt = 0;
    always @(negedge clk) begin
        if (dm_we) we_cnt++;
        if (p0_ack && p1_ack) both_cnt++;
        if (p0_ack) p0_ack_cnt++;
        if (p1_ack) p1_ack_cnt++;
    end

    // One transaction on one port; lat = ack cycle (0 if none within budget).
    task automatic do_req(input bit port, input bit wr, input logic [3:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          output int lat, output logic [DW-1:0] rdata);
        lat = 0;
        rdata = '0;
        if (port) begin
            p1_wr = wr; p1_be = be; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end else begin
            p0_wr = wr; p0_be = be; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (port ? p1_ack : p0_ack) begin
                lat = n;
                rdata = port ? p1_rdata : p0_rdata;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (p0_ack !== 1'b0) begin failures++; $display("FAIL reset_p0_ack got=%b exp=0", p0_ack); end
        checks++; if (p1_ack !== 1'b0) begin failures++; $display("FAIL reset_p1_ack got=%b exp=0", p1_ack); end
        checks++; if (p0_rdata !== 32'h0) begin failures++; $display("FAIL reset_p0_rdata got=%h exp=0", p0_rdata); end
        checks++; if (p1_rdata !== 32'h0) begin failures++; $display("FAIL reset_p1_rdata got=%h exp=0", p1_rdata); end
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL reset_dm_we got=%b exp=0", dm_we); end
        checks++; if (dm_addr !== 10'h0) begin failures++; $display("FAIL reset_dm_addr got=%h exp=0", dm_addr); end
        checks++; if (dm_din !== 32'h0) begin failures++; $display("FAIL reset_dm_din got=%h exp=0", dm_din); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        int lat;
        logic [DW-1:0] rd;
        int p1_before;
        mem[4] <= 32'hDEADBEEF;
        p1_before = p1_ack_cnt;
        @(posedge clk);
        #1;
        do_req(1'b0, 1'b0, 4'h0, 10'h012, 32'h0, lat, rd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", rd); end
        checks++; if (p1_ack_cnt !== p1_before) begin failures++; $display("FAIL read_p1_ack got=%0d exp=%0d", p1_ack_cnt, p1_before); end
    endtask

    task automatic test_full_write();
        int lat;
        logic [DW-1:0] rd;
        int we_before;
        we_before = we_cnt;
        do_req(1'b1, 1'b1, 4'hF, 10'h03C, 32'h12345678, lat, rd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL fullwr_latency got=%0d exp=3", lat); end
        checks++; if (we_cnt - we_before !== 1) begin failures++; $display("FAIL fullwr_we_cycles got=%0d exp=1", we_cnt - we_before); end
        do_req(1'b1, 1'b0, 4'h0, 10'h03C, 32'h0, lat, rd);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL fullwr_readback got=%h exp=12345678", rd); end
    endtask

    task automatic test_partial_write();
        int lat;
        logic [DW-1:0] rd;
        int we_before;
        mem[8] <= 32'hAABBCCDD;
        @(posedge clk);
        #1;
        we_before = we_cnt;
        do_req(1'b0, 1'b1, 4'b0101, 10'h020, 32'h11223344, lat, rd);
        checks++; if (lat !== 4) begin failures++; $display("FAIL partial_latency got=%0d exp=4", lat); end
        checks++; if (we_cnt - we_before !== 1) begin failures++; $display("FAIL partial_we_cycles got=%0d exp=1", we_cnt - we_before); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL partial_rdata_hold got=%h exp=deadbeef", p0_rdata); end
        do_req(1'b0, 1'b0, 4'h0, 10'h020, 32'h0, lat, rd);
        checks++; if (rd !== 32'hAA22CC44) begin failures++; $display("FAIL partial_readback got=%h exp=aa22cc44", rd); end
    endtask

    task automatic test_be_zero();
        int lat;
        logic [DW-1:0] rd;
        int we_before;
        mem[0] <= 32'h55AA55AA;
        @(posedge clk);
        #1;
        we_before = we_cnt;
        do_req(1'b1, 1'b1, 4'h0, 10'h000, 32'hFFFFFFFF, lat, rd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL be0_latency got=%0d exp=3", lat); end
        checks++; if (we_cnt !== we_before) begin failures++; $display("FAIL be0_we_cycles got=%0d exp=0", we_cnt - we_before); end
        checks++; if (mem[0] !== 32'h55AA55AA) begin failures++; $display("FAIL be0_word got=%h exp=55aa55aa", mem[0]); end
    endtask

    task automatic test_back_to_back();
        int order [6];
        int exp_order [6] = '{0, 1, 0, 1, 0, 1};
        int n_acks = 0;
        int last_cyc = 0;
        int both_before;
        mem[16] <= 32'hA0A0A0A0;
        mem[32] <= 32'hB1B1B1B1;
        @(posedge clk);
        #1;
        both_before = both_cnt;
        // Previous grant went to port 1, so port 0 is first.
        p0_wr = 1'b0; p0_addr = 10'h040; p0_req = 1'b1;
        p1_wr = 1'b0; p1_addr = 10'h080; p1_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (p0_ack && n_acks < 6) begin
                order[n_acks] = 0; n_acks++;
                checks++; if (p0_rdata !== 32'hA0A0A0A0) begin failures++; $display("FAIL rr_p0_data got=%h exp=a0a0a0a0", p0_rdata); end
            end
            if (p1_ack && n_acks < 6) begin
                order[n_acks] = 1; n_acks++;
                checks++; if (p1_rdata !== 32'hB1B1B1B1) begin failures++; $display("FAIL rr_p1_data got=%h exp=b1b1b1b1", p1_rdata); end
            end
            if (n_acks == 6) begin
                last_cyc = c;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (n_acks !== 6) begin failures++; $display("FAIL rr_ack_count got=%0d exp=6", n_acks); end
        for (int i = 0; i < n_acks; i++) begin
            checks++;
            if (order[i] !== exp_order[i]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]); end
        end
        checks++; if (last_cyc !== 13) begin failures++; $display("FAIL rr_last_ack_cycle got=%0d exp=13", last_cyc); end
        checks++; if (both_cnt !== both_before) begin failures++; $display("FAIL rr_both_acks got=%0d exp=%0d", both_cnt, both_before); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_merge();
        int p0_before;
        int first_port = -1;
        int first_cyc = 0;
        mem[9] <= 32'h01020304;
        @(posedge clk);
        #1;
        p0_before = p0_ack_cnt;
        // Partial write from port 0 leaves last_grant = 0 before the reset.
        p0_wr = 1'b1; p0_be = 4'b0001; p0_addr = 10'h024; p0_wdata = 32'hFFFFFFFF; p0_req = 1'b1;
        repeat (3) @(negedge clk);  // cycle 3 is MERGE
        checks++; if (dm_we !== 1'b1) begin failures++; $display("FAIL rst_merge_we_before got=%b exp=1", dm_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL rst_merge_we_async got=%b exp=0", dm_we); end
        p0_req = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (mem[9] !== 32'h01020304) begin failures++; $display("FAIL rst_merge_word got=%h exp=01020304", mem[9]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (p0_ack_cnt !== p0_before) begin failures++; $display("FAIL rst_merge_no_ack got=%0d exp=%0d", p0_ack_cnt, p0_before); end
        p0_wr = 1'b0; p0_addr = 10'h040; p0_req = 1'b1;
        p1_wr = 1'b0; p1_addr = 10'h080; p1_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                first_port = p1_ack ? 1 : 0;
                first_cyc = c;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (first_port !== 0) begin failures++; $display("FAIL rst_first_grant got=%0d exp=0", first_port); end
        checks++; if (first_cyc !== 3) begin failures++; $display("FAIL rst_first_latency got=%0d exp=3", first_cyc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        test_reset();
        test_single_read();
        test_full_write();
        test_partial_write();
        test_be_zero();
        test_back_to_back();
        test_reset_in_merge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
